// File: rtl/j_serializer_pkg.sv
// j_serializer_pkg: shared definitions for the j_serializer slice.
//   - ser_state_t : FSM state encoding (2-bit binary, S_IDLE = 2'b00)
//   - SER_WIDTH_DEF / SER_GAP_DEF : default word length and inter-word gap
//   - ser_cnt_width() : counter width covering both WIDTH-1 and GAP-1
package j_serializer_pkg;

  localparam int unsigned SER_WIDTH_DEF = 8;
  localparam int unsigned SER_GAP_DEF   = 0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_GAP   = 2'b10,
    S_DONE  = 2'b11
  } ser_state_t;

  // The one counter is reused for the bit count and the gap count, so it
  // must hold whichever reload value is larger.
  function automatic int unsigned ser_cnt_width(input int unsigned width,
                                                input int unsigned gap);
    int unsigned wb;
    int unsigned gb;
    wb = $clog2(width);
    gb = (gap > 1) ? $clog2(gap) : 1;
    if (wb < 1) wb = 1;
    return (wb > gb) ? wb : gb;
  endfunction

endpackage

// File: rtl/j_serializer_if.sv
// j_serializer_if: load/ready word handshake plus serial output bundle.
//   din       : parallel word (master -> serializer)
//   load      : load request  (master -> serializer)
//   ready     : load will be accepted this cycle
//   j         : serial data bit
//   bit_valid : j carries a data bit
//   done      : one-cycle pulse after the last bit of a word
// Modports: master (word source / observer), slave (the serializer).
interface j_serializer_if
  import j_serializer_pkg::*;
#(
  parameter int unsigned WIDTH = SER_WIDTH_DEF
);
  logic [WIDTH-1:0] din;
  logic             load;
  logic             ready;
  logic             j;
  logic             bit_valid;
  logic             done;

  modport master (output din, load, input ready, j, bit_valid, done);
  modport slave  (input din, load, output ready, j, bit_valid, done);
endinterface

// File: rtl/j_serializer_bit_counter.sv
// ser_bit_counter: loadable down-counter with a zero flag. Used by
// j_serializer for both the bit count and the gap count.
//   clk, rst : clock, asynchronous active-high reset (count -> 0)
//   load     : load load_val (has priority over dec)
//   load_val : reload value
//   dec      : decrement; holds at zero rather than wrapping
//   zero     : count == 0
module ser_bit_counter #(
  parameter int unsigned CW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          dec,
  output logic          zero
);
  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);
endmodule

// File: rtl/j_serializer.sv
// j_serializer: parallel-to-serial feeder for the sequence detector.
// Accepts a WIDTH-bit word on load/ready, drives it on j one bit per clock,
// optionally idles GAP cycles with j=0, then pulses done for one cycle.
// A load during the done cycle is accepted directly (back-to-back words).
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : j_serializer_if.slave (din, load, ready, j, bit_valid, done)
// Parameters: WIDTH (2..32), GAP (0..15).
// Build option: define SER_LSB_FIRST_EN to emit words LSB first
// (default is MSB first); handshake and timing are unchanged.
module j_serializer
  import j_serializer_pkg::*;
#(
  parameter int unsigned WIDTH = SER_WIDTH_DEF,
  parameter int unsigned GAP   = SER_GAP_DEF
) (
  input  logic            clk,
  input  logic            rst,
  j_serializer_if.slave   bus
);
  localparam int unsigned   CW       = ser_cnt_width(WIDTH, GAP);
  localparam logic [CW-1:0] BIT_LOAD = CW'(WIDTH - 1);
  localparam logic [CW-1:0] GAP_LOAD = (GAP > 0) ? CW'(GAP - 1) : '0;

  ser_state_t       state, state_d;
  logic [WIDTH-1:0] shreg;
  logic             accept;
  logic             shift_en;
  logic             cnt_load;
  logic [CW-1:0]    cnt_val;
  logic             cnt_dec;
  logic             cnt_zero;
  logic             ser_bit;

  ser_bit_counter #(
    .CW (CW)
  ) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d  = state;
    accept   = 1'b0;
    shift_en = 1'b0;
    cnt_load = 1'b0;
    cnt_val  = BIT_LOAD;
    cnt_dec  = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.load) begin
          accept   = 1'b1;
          cnt_load = 1'b1;
          state_d  = S_SHIFT;
        end
      end
      S_SHIFT: begin
        shift_en = 1'b1;
        if (cnt_zero) begin
          if (GAP > 0) begin
            cnt_load = 1'b1;
            cnt_val  = GAP_LOAD;
            state_d  = S_GAP;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          cnt_dec = 1'b1;
        end
      end
      S_GAP: begin
        if (cnt_zero) begin
          state_d = S_DONE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      S_DONE: begin
        if (bus.load) begin
          accept   = 1'b1;
          cnt_load = 1'b1;
          state_d  = S_SHIFT;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg <= '0;
    end else if (accept) begin
      shreg <= bus.din;
    end else if (shift_en) begin
`ifdef SER_LSB_FIRST_EN
      shreg <= {1'b0, shreg[WIDTH-1:1]};
`else
      shreg <= {shreg[WIDTH-2:0], 1'b0};
`endif
    end
  end

`ifdef SER_LSB_FIRST_EN
  assign ser_bit = shreg[0];
`else
  assign ser_bit = shreg[WIDTH-1];
`endif

  // Outputs decode state/shift register only, never the inputs.
  assign bus.j         = (state == S_SHIFT) && ser_bit;
  assign bus.bit_valid = (state == S_SHIFT);
  assign bus.done      = (state == S_DONE);
  assign bus.ready     = (state == S_IDLE) || (state == S_DONE);
endmodule
